// File: rtl/debounced_switch_leds.sv
// Per-channel switch debouncer driving LEDs in follow or toggle mode.
// Each channel: 2-flop synchroniser, saturating debounce counter, press pulse and toggle latch.
module debounced_switch_leds #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [NUM_CH-1:0] iSwitch,
    input  logic              iMode,
    output logic [NUM_CH-1:0] oLED,
    output logic [NUM_CH-1:0] oPress
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] syncMeta_q;
    logic [NUM_CH-1:0] syncOut_q;
    logic [NUM_CH-1:0] stable_q;
    logic [NUM_CH-1:0] stable_d;
    logic [NUM_CH-1:0] toggle_q;
    logic [NUM_CH-1:0] toggle_d;
    logic [NUM_CH-1:0] press_q;
    logic [NUM_CH-1:0] press_d;
    logic [CW-1:0]     count_q [NUM_CH];
    logic [CW-1:0]     count_d [NUM_CH];

    // A channel is accepted only after the synchronised level has disagreed with
    // the stable level for DEBOUNCE_CYCLES consecutive edges; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        toggle_d = toggle_q;
        press_d  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            count_d[ch] = '0;
            if (syncOut_q[ch] != stable_q[ch]) begin
                if (count_q[ch] == CNT_MAX) begin
                    stable_d[ch] = syncOut_q[ch];
                    if (syncOut_q[ch]) begin
                        press_d[ch]  = 1'b1;
                        toggle_d[ch] = ~toggle_q[ch];
                    end
                end else begin
                    count_d[ch] = count_q[ch] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncMeta_q <= '0;
            syncOut_q  <= '0;
            stable_q   <= '0;
            toggle_q   <= '0;
            press_q    <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                count_q[ch] <= '0;
            end
        end else begin
            syncMeta_q <= iSwitch;
            syncOut_q  <= syncMeta_q;
            stable_q   <= stable_d;
            toggle_q   <= toggle_d;
            press_q    <= press_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                count_q[ch] <= count_d[ch];
            end
        end
    end

    // Mode select is purely combinational so a mode change shows immediately.
    assign oLED   = iMode ? toggle_q : stable_q;
    assign oPress = press_q;

endmodule

// File: tb/tb_debounced_switch_leds.sv
// Self-checking bench for debounced_switch_leds (NUM_CH=4, DEBOUNCE_CYCLES=4).
// Each scenario task pushes the expected outputs per edge and pops them after the edge.
module tb_debounced_switch_leds;

    localparam int NUM_CH = 4;
    localparam int DC     = 4;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] press;
    } exp_t;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iMode;
    logic [3:0] iSwitch;
    logic [3:0] oLED;
    logic [3:0] oPress;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;

    debounced_switch_leds #(
        .NUM_CH         (NUM_CH),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iSwitch(iSwitch),
        .iMode  (iMode),
        .oLED   (oLED),
        .oPress (oPress)
    );

    always #5 iClk = ~iClk;

    task automatic applyReset();
        iRst    = 1'b1;
        iSwitch = 4'b0000;
        iMode   = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        sbQ.delete();
    endtask

    // Reset with switches high, then held-high switches accepted 2+DC edges after the last reset edge.
    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            iRst    = (i < 2);
            iSwitch = 4'b1111;
            iMode   = 1'b0;
            e.led   = (i >= 7) ? 4'b1111 : 4'b0000;
            e.press = (i == 7) ? 4'b1111 : 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL reset edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
            if (i < 2) begin
                iMode = 1'b1;
                #1;
                total++;
                if ({oLED, oPress} !== 8'h00) begin
                    bad++;
                    $display("[TB] FAIL reset_toggle_mode edge %0d: oLED=%b oPress=%b, expected 0000/0000",
                             i, oLED, oPress);
                end
                iMode = 1'b0;
            end
        end
        iRst = 1'b0;
    endtask

    task automatic test_follow();
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            iMode   = 1'b0;
            iSwitch = (i < 10) ? 4'b0001 : 4'b0000;
            e.led   = (i >= 5 && i < 15) ? 4'b0001 : 4'b0000;
            e.press = (i == 5) ? 4'b0001 : 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL follow edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
        end
    endtask

    // A three-cycle pulse reaches a count of DC-1 at most and must be discarded.
    task automatic test_glitch();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            iMode   = 1'b0;
            iSwitch = (i < 3) ? 4'b0010 : 4'b0000;
            e.led   = 4'b0000;
            e.press = 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL glitch edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
        end
    endtask

    task automatic test_toggle();
        exp_t e;
        for (int i = 0; i < 36; i++) begin
            iMode   = 1'b1;
            iSwitch = (((i / 8) % 2 == 0) && i < 32) ? 4'b0100 : 4'b0000;
            e.led   = (i >= 5 && i < 21) ? 4'b0100 : 4'b0000;
            e.press = (i == 5 || i == 21) ? 4'b0100 : 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL toggle edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
        end
    endtask

    // All channels accepted together, then mode flips between stable and toggle views.
    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            iMode   = (i < 10 || i >= 20);
            iSwitch = (i < 10) ? 4'b1111 : 4'b0000;
            if (i == 20) begin
                #1;
                total++;
                if (oLED !== 4'b1111) begin
                    bad++;
                    $display("[TB] FAIL mode_switch_immediate: oLED=%b, expected 1111", oLED);
                end
            end
            e.led   = (i >= 5 && i < 15) || (i >= 20) ? 4'b1111 : 4'b0000;
            e.press = (i == 5) ? 4'b1111 : 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL simultaneous edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
        end
    endtask

    // Reset on edge 3 throws away the partial count; acceptance lands on edge 3+2+DC.
    task automatic test_reset_mid_debounce();
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            iMode   = 1'b0;
            iRst    = (i == 3);
            iSwitch = 4'b1000;
            e.led   = (i >= 9) ? 4'b1000 : 4'b0000;
            e.press = (i == 9) ? 4'b1000 : 4'b0000;
            sbQ.push_back(e);
            @(posedge iClk);
            #1;
            e = sbQ.pop_front();
            total++;
            if ({oLED, oPress} !== e) begin
                bad++;
                $display("[TB] FAIL reset_mid edge %0d: oLED=%b oPress=%b, expected oLED=%b oPress=%b",
                         i, oLED, oPress, e.led, e.press);
            end
        end
        iRst = 1'b0;
    endtask

    initial begin
        iRst    = 1'b1;
        iMode   = 1'b0;
        iSwitch = 4'b0000;
        test_reset();
        applyReset();
        test_follow();
        applyReset();
        test_glitch();
        applyReset();
        test_toggle();
        applyReset();
        test_back_to_back();
        applyReset();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
